// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier and its register file.
// Provides the controller state encoding and the default operand/address widths.
// No ports; imported with mul_pkg::* by the multiplier.
package mul_pkg;

  // Default operand width; the product is 2*DEF_W bits.
  localparam int DEF_W  = 8;
  // Default register address width, kept in step with the register file.
  localparam int DEF_PW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WR_LO = 2'd2,
    WR_HI = 2'd3
  } mul_state_t;

endpackage : mul_pkg

// File: rtl/shift_mul.sv
// Iterative unsigned WxW shift-add multiplier that writes its 2W-bit product back
// into the register file: low byte to the captured destination, then high byte to r0.
// Ports: clk/rst_n; start, op_a, op_b, dst_addr in; busy, done and the write port
// (wr_en, in_place, wr_addr, dat_out) out.
module shift_mul
  import mul_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int PW = DEF_PW,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  op_a,
  input  logic [W-1:0]  op_b,
  input  logic [PW-1:0] dst_addr,
  output logic          busy,
  output logic          done,
  output logic          wr_en,
  output logic          in_place,
  output logic [PW-1:0] wr_addr,
  output logic [W-1:0]  dat_out
);

  mul_state_t    state_q, state_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] dst_q, dst_d;

  // Partial-sum adder on the upper half of the accumulator; the extra bit keeps the
  // carry so it can be shifted back into the accumulator's MSB.
  logic [W:0] sum;
  assign sum = {1'b0, acc_q[2*W-1:W]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dst_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dst_q    <= dst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dst_d    = dst_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CALC;
          mcand_d  = op_a;
          mplier_d = op_b;
          dst_d    = dst_addr;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      CALC: begin
        // Shift {carry, acc} right by one; the consumed multiplier bit falls off.
        acc_d    = {sum, acc_q[W-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = WR_LO;
        end
      end
      WR_LO:   state_d = WR_HI;
      WR_HI:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: purely a function of state and registered data, so an
  // asynchronous reset forces them all low immediately.
  always_comb begin
    busy     = (state_q != IDLE);
    done     = 1'b0;
    wr_en    = 1'b0;
    in_place = 1'b0;
    wr_addr  = '0;
    dat_out  = '0;
    unique case (state_q)
      WR_LO: begin
        wr_en    = 1'b1;
        in_place = 1'b1;
        wr_addr  = dst_q;
        dat_out  = acc_q[W-1:0];
      end
      WR_HI: begin
        wr_en    = 1'b1;
        done     = 1'b1;
        dat_out  = acc_q[2*W-1:W];
      end
      default: ;
    endcase
  end

endmodule : shift_mul

// File: tb/tb_shift_mul.sv
// Self-checking bench for shift_mul: timeline model of the expected outputs,
// register-file write log with literal expectations, and randomized traffic.
module tb_shift_mul;

  localparam int W  = 8;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [PW-1:0] dst_addr;
  logic          busy;
  logic          done;
  logic          wr_en;
  logic          in_place;
  logic [PW-1:0] wr_addr;
  logic [W-1:0]  dat_out;

  shift_mul #(.W(W), .PW(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .dst_addr (dst_addr),
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .in_place (in_place),
    .wr_addr  (wr_addr),
    .dat_out  (dat_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: m_k counts cycles since the accepted start edge
  // (0 = idle, 1..W = computing, W+1 = low write, W+2 = high write).
  int           m_k = 0;
  logic [W-1:0] m_a, m_b;
  logic [PW-1:0] m_dst;

  always @(posedge clk) begin
    if (!rst_n) m_k = 0;
    else if (m_k == 0) begin
      if (start === 1'b1) begin
        m_a = op_a; m_b = op_b; m_dst = dst_addr; m_k = 1;
      end
    end else if (m_k == W + 2) m_k = 0;
    else m_k++;
  end

  always @(negedge rst_n) m_k = 0;

  function automatic logic [14:0] m_exp();
    logic [15:0] p;
    logic lo, hi;
    p  = 16'(m_a) * 16'(m_b);
    lo = (m_k == W + 1);
    hi = (m_k == W + 2);
    return {m_k != 0, hi, lo | hi, lo, lo ? m_dst : 3'd0,
            lo ? p[7:0] : (hi ? p[15:8] : 8'd0)};
  endfunction

  always @(negedge clk) begin
    chk("cycle_outputs", 32'({busy, done, wr_en, in_place, wr_addr, dat_out}), 32'(m_exp()));
  end

  // Register-file write log taken from the DUT's write port.
  int           cyc = 0;
  int           wc[$];
  logic [10:0]  wd[$];

  always @(posedge clk) begin
    if (wr_en === 1'b1) begin
      wc.push_back(cyc);
      wd.push_back({(in_place ? wr_addr : 3'd0), dat_out});
    end
    cyc <= cyc + 1;
  end

  task automatic check_writes(input string name, input int e0, input logic [2:0] d,
                              input logic [7:0] lo, input logic [7:0] hi);
    chk({name, "_nwrites"}, wd.size(), 2);
    if (wd.size() == 2) begin
      chk({name, "_lo_edge"}, wc[0] - e0, W + 1);
      chk({name, "_lo_wr"}, 32'(wd[0]), 32'({d, lo}));
      chk({name, "_hi_edge"}, wc[1] - e0, W + 2);
      chk({name, "_hi_wr"}, 32'(wd[1]), 32'({3'd0, hi}));
    end
  endtask

  // One operation: start at the next negedge, operands scrambled afterwards,
  // optional stray start pulse on cycle inj after the start edge.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] d,
                       input int inj, output int e0, output int bcnt);
    wc.delete(); wd.delete();
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; dst_addr = d;
    e0 = cyc;
    bcnt = 0;
    for (int i = 1; i <= W + 3; i++) begin
      @(negedge clk);
      start    = (i == inj);
      op_a     = 8'($urandom);
      op_b     = 8'($urandom);
      dst_addr = 3'($urandom);
      if (busy === 1'b1) bcnt++;
    end
    start = 1'b0;
  endtask

  int e0, bc;

  initial begin
    rst_n = 1'b1; start = 1'b0; op_a = '0; op_b = '0; dst_addr = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_state", 32'({busy, done, wr_en, in_place, wr_addr, dat_out}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(8'd13, 8'd11, 3'd3, 0, e0, bc);
    check_writes("13x11", e0, 3'd3, 8'h8F, 8'h00);

    do_op(8'hFF, 8'hFF, 3'd5, 0, e0, bc);
    check_writes("ffxff", e0, 3'd5, 8'h01, 8'hFE);
    chk("ffxff_busy_cycles", bc, 10);

    do_op(8'h00, 8'hA7, 3'd1, 0, e0, bc);
    check_writes("00xa7", e0, 3'd1, 8'h00, 8'h00);
    do_op(8'h01, 8'hA7, 3'd6, 0, e0, bc);
    check_writes("01xa7", e0, 3'd6, 8'hA7, 8'h00);

    // Stray start in CALC cycle 4 must neither disturb nor queue an operation.
    do_op(8'd200, 8'd3, 3'd7, 4, e0, bc);
    check_writes("start_in_calc", e0, 3'd7, 8'h58, 8'h02);
    chk("start_in_calc_busy", bc, 10);

    // Reset during CALC cycle 5.
    wc.delete(); wd.delete();
    @(negedge clk); start = 1'b1; op_a = 8'd9; op_b = 8'd9; dst_addr = 3'd4;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'({busy, done, wr_en, in_place, wr_addr, dat_out}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_write_after_reset", wd.size(), 0);
    do_op(8'd6, 8'd7, 3'd2, 0, e0, bc);
    check_writes("6x7_after_reset", e0, 3'd2, 8'h2A, 8'h00);

    do_op(8'h10, 8'h20, 3'd0, 0, e0, bc);
    check_writes("dst0", e0, 3'd0, 8'h00, 8'h02);

    // Randomized traffic, including back-to-back starts and starts while busy.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 2) == 0);
      op_a     = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      op_b     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      dst_addr = 3'($urandom);
    end
    @(negedge clk); start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_shift_mul

// File: doc/shift_mul.md
# shift_mul

Iterative unsigned 8×8 shift-add multiplier that sits directly downstream of the register file's read ports and loops back into its write port. It captures the two register operands on a start pulse and computes the 16-bit product in W cycles. It then drives the register-file write interface for two cycles: the low byte goes to the destination register (in-place write) and the high byte goes to r0 (the accumulator write path).

## Interface
- `W`, 8, operand width; product is 2W bits.
- `PW`, 3, register address width; matches the register file.
- `CW`, $clog2(W+1), width of the step counter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `op_a`  in  W  multiplicand, from register-file read port A.
- `op_b`  in  W  multiplier, from register-file read port B.
- `dst_addr`  in  PW  destination register for the low byte.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse during the final write cycle.
- `wr_en`  out  1  register-file write enable.
- `in_place`  out  1  1 selects `wr_addr`; 0 selects r0.
- `wr_addr`  out  PW  register-file write address.
- `dat_out`  out  W  register-file write data.

## Operation
- States:
  - IDLE: on `start`, go to CALC. Capture `op_a`, `op_b` and `dst_addr`. Clear the accumulator and set the counter to 0.
  - CALC: each cycle, if multiplier bit 0 = 1, acc[2W-1:W] += multiplicand, with the carry kept in a (W+1)-bit sum. Then shift {carry, acc} right by 1 and the multiplier right by 1, and increment the counter. After step W, go to WR_LO.
  - WR_LO: `wr_en`=1, `in_place`=1, `wr_addr`=captured `dst_addr`, `dat_out`=product[W-1:0]. Next state is WR_HI.
  - WR_HI: `wr_en`=1, `in_place`=0, `wr_addr`=0, `dat_out`=product[2W-1:W], `done`=1. Next state is IDLE.
- Outputs are Moore-decoded from state and registered data. In IDLE and CALC, `wr_en`, `in_place`, `wr_addr`, `dat_out` and `done` are all 0.
- `start` while `busy`=1 is ignored. No queueing, no error flag.
- Operands are captured at the start edge. Later changes on `op_a`, `op_b` or `dst_addr` have no effect on the result.
- If `dst_addr`=0, both writes target r0 and the high byte lands last. The final r0 value is therefore product[2W-1:W].
- Arithmetic is unsigned only; no overflow is possible in 2W bits.
- Reset, at any time including mid-CALC or mid-write: state goes to IDLE and the accumulator, counter and captured registers clear to 0. All outputs drop to 0 immediately (asynchronously). No partial write completes after reset is asserted.

## Timing
- Start sampled at edge E0. CALC occupies the cycles after E0 through E_W. WR_LO occupies the cycle after E_W, and WR_HI the next cycle.
- The register file commits the low byte at edge E_(W+1) and the high byte at edge E_(W+2).
- Fixed latency from start edge to final write edge: W+2 = 10 cycles at W=8.
- `busy` rises in the cycle after E0 and falls in the cycle after E_(W+2).
- `start` may be re-asserted in the first IDLE cycle after `done`. Back-to-back throughput is one operation per W+3 cycles.
- Reset values: `busy`=0, `done`=0, `wr_en`=0, `in_place`=0, `wr_addr`=0, `dat_out`=0.

## Structure
- Shared package `mul_pkg`:
  - `typedef enum logic [1:0] {IDLE, CALC, WR_LO, WR_HI} mul_state_t`.
  - Default width constants W=8 and PW=3, shared with the register-file instantiation.
- Single module. The datapath (accumulator, adder, shifter) is small enough to keep inline, so no sub-module is warranted.
- The top-level processor muxes `wr_en`, `wr_addr`, `in_place` and `dat_out` with the normal writeback path, selecting this block while `busy`=1.

## Test plan
- 13×11, `dst_addr`=3, `start` at E0 → write 0x8F to r3 at E9, then 0x00 to r0 at E10. `done` high only in the cycle before E10.
- 0xFF×0xFF, `dst_addr`=5 → r5=0x01, r0=0xFE. `busy` high for exactly 10 cycles.
- 0x00×0xA7 and 0x01×0xA7 → products 0x0000 and 0x00A7. Both writes still occur with fixed latency.
- `start` pulsed in CALC cycle 4 with different operands → ignored; the first result is unchanged and no second operation runs.
- `rst_n` low during CALC cycle 5 → all outputs 0 immediately and no `wr_en`. After release, a new `start` with 6×7 yields lo 0x2A, hi 0x00.
- `dst_addr`=0, 0x10×0x20 → WR_LO writes 0x00 to r0, then WR_HI writes 0x02 to r0; final r0 = 0x02.
